// File: rtl/paint_pkg.sv
// Shared definitions for the paint pipeline: canvas geometry, colour codes,
// the brush_stamper state encoding and small coordinate helpers.
package paint_pkg;

    localparam int CANVAS_DIM  = 128;
    localparam int CANVAS_BITS = $clog2(CANVAS_DIM);
    localparam int MAX_RADIUS  = 3;
    localparam int SIZE_W      = $clog2(MAX_RADIUS + 1);
    localparam int OFF_W       = SIZE_W + 1;   // signed brush offset -r..+r
    localparam int COORD_W     = 10;
    localparam int PIX_W       = COORD_W + 1;  // signed target coordinate, never wraps
    localparam int COLOR_W     = 3;

    localparam logic [COLOR_W-1:0] ERASE  = 3'd0;
    localparam logic [COLOR_W-1:0] RED    = 3'd1;
    localparam logic [COLOR_W-1:0] GREEN  = 3'd2;
    localparam logic [COLOR_W-1:0] BLUE   = 3'd3;
    localparam logic [COLOR_W-1:0] YELLOW = 3'd4;
    localparam logic [COLOR_W-1:0] PURPLE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Centre plus signed offset, widened by one bit so negatives and
    // far-right targets stay distinguishable from on-canvas pixels.
    function automatic logic [PIX_W-1:0] offset_coord(input logic [COORD_W-1:0] c,
                                                      input logic [OFF_W-1:0]   d);
        return {1'b0, c} + {{(PIX_W - OFF_W){d[OFF_W-1]}}, d};
    endfunction

    // On canvas iff non-negative and below CANVAS_DIM; with a power-of-two
    // canvas that is simply "all bits above the pixel index are zero".
    function automatic logic in_canvas(input logic [PIX_W-1:0] v);
        return (v[PIX_W-1:CANVAS_BITS] == '0);
    endfunction

endpackage

// File: rtl/stamp_scan.sv
// Row-major offset generator for a square brush of radius r: walks dy outer,
// dx inner, both from -r to +r, one step per strobe. Shared with the cursor
// overlay, so it keeps its own copy of r.
module stamp_scan
    import paint_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [SIZE_W-1:0]       r_i,
    input  logic                    step_i,
    output logic signed [OFF_W-1:0] dx_o,
    output logic signed [OFF_W-1:0] dy_o,
    output logic                    last_o
);

    localparam logic signed [OFF_W-1:0] ONE = OFF_W'(1);

    logic [SIZE_W-1:0]       r_q, r_d;
    logic signed [OFF_W-1:0] dx_q, dx_d;
    logic signed [OFF_W-1:0] dy_q, dy_d;

    logic signed [OFF_W-1:0] pos_r;
    logic signed [OFF_W-1:0] neg_r;
    logic signed [OFF_W-1:0] neg_r_in;
    logic                    row_end;

    assign pos_r    = signed'({1'b0, r_q});
    assign neg_r    = -pos_r;
    assign neg_r_in = -signed'({1'b0, r_i});
    assign row_end  = (dx_q == pos_r);
    assign last_o   = row_end && (dy_q == pos_r);
    assign dx_o     = dx_q;
    assign dy_o     = dy_q;

    // Next offset: reload on a new command, otherwise step and hold at the end.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        r_d  = r_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (load_i) begin
            r_d  = r_i;
            dx_d = neg_r_in;
            dy_d = neg_r_in;
        end else if (step_i && !last_o) begin
            if (row_end) begin
                dx_d = neg_r;
                dy_d = dy_q + ONE;
            end else begin
                dx_d = dx_q + ONE;
            end
        end
    end

    // Offset and radius registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            r_q  <= r_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/brush_stamper.sv
// Write-side producer for the pixel store. Turns stamp / clear commands into
// one-pixel writes, clipping to the canvas and honouring the store's
// wr_ready backpressure. Pulses done once per completed command.
module brush_stamper
    import paint_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_clear,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic [SIZE_W-1:0]  cmd_size,
    input  logic               wr_ready,
    output logic               brush,
    output logic [COLOR_W-1:0] newColor,
    output logic [COORD_W-1:0] wx,
    output logic [COORD_W-1:0] wy,
    output logic               done
);

    state_e                 state_q, state_d;
    logic [COORD_W-1:0]     x_q, x_d;
    logic [COORD_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0]     color_q, color_d;
    logic [CANVAS_BITS-1:0] cx_q, cx_d;
    logic [CANVAS_BITS-1:0] cy_q, cy_d;
    logic                   done_q, done_d;

    logic                    accept;
    logic                    advance;
    logic                    scan_step;
    logic                    scan_last;
    logic signed [OFF_W-1:0] dx;
    logic signed [OFF_W-1:0] dy;
    logic [PIX_W-1:0]        px;
    logic [PIX_W-1:0]        py;
    logic                    pix_in;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign scan_step = (state_q == ST_DRAW) && advance;
    assign done      = done_q;

    stamp_scan u_scan (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (accept),
        .r_i    (cmd_size),
        .step_i (scan_step),
        .dx_o   (dx),
        .dy_o   (dy),
        .last_o (scan_last)
    );

    assign px     = offset_coord(x_q, dx);
    assign py     = offset_coord(y_q, dy);
    assign pix_in = in_canvas(px) && in_canvas(py);

    // Write port: present the current pixel; a write retires only when the
    // store is ready, while a clipped offset retires unconditionally.
    always_comb begin
        brush    = 1'b0;
        newColor = '0;
        wx       = '0;
        wy       = '0;
        advance  = 1'b0;
        case (state_q)
            ST_DRAW: begin
                if (pix_in) begin
                    brush    = 1'b1;
                    newColor = color_q;
                    wx       = px[COORD_W-1:0];
                    wy       = py[COORD_W-1:0];
                    advance  = wr_ready;
                end else begin
                    advance  = 1'b1;
                end
            end
            ST_CLEAR: begin
                brush    = 1'b1;
                newColor = ERASE;
                wx       = COORD_W'(cx_q);
                wy       = COORD_W'(cy_q);
                advance  = wr_ready;
            end
            default: ;
        endcase
    end

    // Command latch, clear sweep and state sequencing.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    color_d = cmd_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = cmd_clear ? ST_CLEAR : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (advance && scan_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (advance) begin
                    if (&cx_q) begin
                        // Sweep ends on the bottom-right pixel; the
                        // counters hold there instead of wrapping.
                        if (&cy_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cx_d = '0;
                            cy_d = cy_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched command registers; reset abandons any command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_brush_stamper.sv
// Self-checking bench for brush_stamper: directed corner cases plus random
// stamps, compared against a clipped row-major write list built from plain
// integer arithmetic.
module tb_brush_stamper;

    localparam int DIM = 128;
    localparam int C_ERASE = 0;
    localparam int C_RED   = 1;
    localparam int C_GREEN = 2;

    typedef struct {
        int x;
        int y;
        int c;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_clear;
    logic [9:0] cmd_x;
    logic [9:0] cmd_y;
    logic [2:0] cmd_color;
    logic [1:0] cmd_size;
    logic       wr_ready;
    logic       brush;
    logic [2:0] newColor;
    logic [9:0] wx;
    logic [9:0] wy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    wr_t exp_q[$];
    wr_t act_q[$];
    int  last_busy;
    int  last_stalls;
    int  last_first;

    brush_stamper dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_color (cmd_color),
        .cmd_size  (cmd_size),
        .wr_ready  (wr_ready),
        .brush     (brush),
        .newColor  (newColor),
        .wx        (wx),
        .wy        (wy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Expected write list: every offset of the square in row-major order,
    // keeping only pixels that land on the canvas.
    function automatic void build_model(input bit clr, input int x, input int y,
                                        input int c, input int r);
        exp_q.delete();
        if (clr) begin
            for (int j = 0; j < DIM; j++)
                for (int i = 0; i < DIM; i++)
                    exp_q.push_back('{x: i, y: j, c: C_ERASE});
        end else begin
            for (int dy = -r; dy <= r; dy++)
                for (int dx = -r; dx <= r; dx++)
                    if (x + dx >= 0 && x + dx < DIM && y + dy >= 0 && y + dy < DIM)
                        exp_q.push_back('{x: x + dx, y: y + dy, c: c});
        end
    endfunction

    // mode: 0 = store always ready, 1 = ready toggles starting low, 2 = random.
    // noise: throw junk commands at the block while it is busy.
    task automatic run_cmd(input string tag, input bit clr, input int x, input int y,
                           input int c, input int r, input int mode, input bit noise);
        int  budget;
        int  offsets;
        bit  got_done;
        bit  hold;
        int  hold_err;
        int  ready_err;
        int  first_bad;
        logic [9:0] hx;
        logic [9:0] hy;
        logic [2:0] hc;

        build_model(clr, x, y, c, r);
        act_q.delete();
        offsets = clr ? DIM * DIM : (2 * r + 1) * (2 * r + 1);
        budget  = clr ? 40000 : 2000;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_clear = clr;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_color = 3'(c);
        cmd_size  = 2'(r);
        wr_ready  = 1'b1;
        #1;
        check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);

        last_busy   = 0;
        last_stalls = 0;
        last_first  = -1;
        got_done    = 1'b0;
        hold        = 1'b0;
        hold_err    = 0;
        ready_err   = 0;
        hx = '0; hy = '0; hc = '0;

        for (int cyc = 1; cyc <= budget && !got_done; cyc++) begin
            @(negedge clk);
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_clear = 1'($urandom_range(0, 1));
                cmd_x     = 10'($urandom_range(0, 1023));
                cmd_y     = 10'($urandom_range(0, 1023));
                cmd_color = 3'($urandom_range(0, 7));
                cmd_size  = 2'($urandom_range(0, 3));
            end else begin
                cmd_valid = 1'b0;
            end
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (cyc % 2 == 0);
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (done === 1'b1) begin
                got_done  = 1'b1;
                cmd_valid = 1'b0;
                check({tag, "_brush_at_done"}, 32'(brush), 32'd0);
                check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
            end else begin
                last_busy++;
                if (cmd_ready !== 1'b0) ready_err++;
                if (hold && (brush !== 1'b1 || wx !== hx || wy !== hy || newColor !== hc))
                    hold_err++;
                if (brush === 1'b1) begin
                    if (last_first < 0) last_first = cyc;
                    if (wr_ready) act_q.push_back('{x: int'(wx), y: int'(wy), c: int'(newColor)});
                    else last_stalls++;
                end
                hold = (brush === 1'b1) && !wr_ready;
                hx = wx;
                hy = wy;
                hc = newColor;
            end
        end
        cmd_valid = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);

        @(negedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);

        check({tag, "_busy_not_ready"}, 32'(ready_err), 32'd0);
        check({tag, "_hold_stable"}, 32'(hold_err), 32'd0);
        check({tag, "_n_writes"}, 32'(act_q.size()), 32'(exp_q.size()));
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            if (first_bad < 0 && act_q[i] != exp_q[i]) first_bad = i;
        check({tag, "_first_bad_write_idx"}, 32'(first_bad), -32'sd1);
        check({tag, "_scan_cycles"}, 32'(last_busy), 32'(offsets + last_stalls));
    endtask

    initial begin
        int err_cnt;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_color = '0;
        cmd_size  = '0;
        wr_ready  = 1'b0;

        // Reset values, during and after reset.
        repeat (3) @(negedge clk);
        check("rst_brush", 32'(brush), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_brush", 32'(brush), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_wx", 32'(wx), 32'd0);
        check("post_rst_wy", 32'(wy), 32'd0);
        check("post_rst_color", 32'(newColor), 32'd0);

        // Single pixel: written in the first cycle after accept.
        run_cmd("single", 1'b0, 5, 7, C_GREEN, 0, 0, 1'b0);
        check("single_first_cycle", 32'(last_first), 32'd1);
        check("single_busy", 32'(last_busy), 32'd1);

        // Corner clip: 4 writes out of 9 offsets.
        run_cmd("corner", 1'b0, 0, 0, C_RED, 1, 0, 1'b0);
        check("corner_busy", 32'(last_busy), 32'd9);

        // Fully off canvas: 25 silent scan cycles.
        run_cmd("offcanvas", 1'b0, 200, 10, 4, 2, 0, 1'b0);
        check("offcanvas_busy", 32'(last_busy), 32'd25);
        check("offcanvas_stalls", 32'(last_stalls), 32'd0);

        // Toggling backpressure plus junk commands while busy.
        run_cmd("bp", 1'b0, 10, 10, 5, 1, 1, 1'b1);
        check("bp_stalls", 32'(last_stalls), 32'd9);
        check("bp_busy", 32'(last_busy), 32'd18);

        // Random stamps, random backpressure, random busy-time noise.
        for (int n = 0; n < 40; n++) begin
            int rx;
            int ry;
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 131));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 131));
            run_cmd($sformatf("rand%0d", n), 1'b0, rx, ry, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a stamp.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_clear = 1'b0;
        cmd_x     = 10'd60;
        cmd_y     = 10'd60;
        cmd_color = 3'd5;
        cmd_size  = 2'd3;
        wr_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_busy_before", 32'(brush), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_brush", 32'(brush), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_wx", 32'(wx), 32'd0);
        check("midrst_wy", 32'(wy), 32'd0);
        check("midrst_color", 32'(newColor), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        err_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || brush !== 1'b0) err_cnt++;
        end
        check("midrst_stays_idle", 32'(err_cnt), 32'd0);

        // Full-canvas clear.
        run_cmd("clear", 1'b1, 0, 0, 0, 0, 0, 1'b0);
        check("clear_busy", 32'(last_busy), 32'(DIM * DIM));
        if (act_q.size() > 0) begin
            check("clear_first_x", 32'(act_q[0].x), 32'd0);
            check("clear_first_y", 32'(act_q[0].y), 32'd0);
            check("clear_last_x", 32'(act_q[act_q.size() - 1].x), 32'(DIM - 1));
            check("clear_last_y", 32'(act_q[act_q.size() - 1].y), 32'(DIM - 1));
        end

        // Block still usable after a clear.
        run_cmd("after_clear", 1'b0, 127, 127, 3, 2, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
